neureka_job_dispatcher: RTL and testbench

Peripheral-side initiator that drives the NEUREKA control slave port. It takes one job descriptor at a time from a ready/valid input and acquires a job context through the ACQUIRE register, retrying with backoff while no context is free. It then writes all job registers, writes TRIGGER, and waits for the job-end event before reporting completion. It sits between a host/DMA-side job queue and the accelerator, replacing core-driven offload.

---
 rtl/neureka_job_dispatcher.sv | 259 +++++++++++++++++++++++++
 tb/tb_neureka_job_dispatcher.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_job_dispatcher.sv
// neureka_job_dispatcher
//   Peripheral-side initiator for the NEUREKA control slave port. It accepts
//   one job descriptor at a time and acquires a job context through ACQUIRE,
//   retrying after a fixed idle interval while no context is free. It then
//   writes every job register and TRIGGER, and waits for the job-end event.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   desc_valid_i/ready_o    descriptor handshake
//   desc_data_i             N_REGS x 32-bit job register values (word i -> reg i)
//   periph_req_o/gnt_i      request/grant of the control port
//   periph_add_o/wen_o/be_o/data_o/id_o   request fields (wen: 0 write, 1 read)
//   periph_r_valid_i/r_data_i/r_id_i      response channel (reads and writes)
//   evt_i                   job-end event for this initiator
//   busy_o                  dispatcher not idle
//   job_id_o                context ID from the last successful ACQUIRE
//   done_o                  one-cycle pulse on job end
//   err_o                   sticky response-ID mismatch, cleared on next accept
module neureka_job_dispatcher #(
    parameter int unsigned N_REGS    = 24,
    parameter int unsigned ID_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] JOB_OFFS  = 32'h20,
    parameter int unsigned BACKOFF   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [32*N_REGS-1:0]  desc_data_i,
    output logic                  periph_req_o,
    input  logic                  periph_gnt_i,
    output logic [31:0]           periph_add_o,
    output logic                  periph_wen_o,
    output logic [3:0]            periph_be_o,
    output logic [31:0]           periph_data_o,
    output logic [ID_WIDTH-1:0]   periph_id_o,
    input  logic                  periph_r_valid_i,
    input  logic [31:0]           periph_r_data_i,
    input  logic [ID_WIDTH-1:0]   periph_r_id_i,
    input  logic                  evt_i,
    output logic                  busy_o,
    output logic [7:0]            job_id_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned CNT_W     = $clog2(BACKOFF + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BACKOFF - 1);
    localparam logic [31:0] ACQ_ADDR  = BASE_ADDR + 32'h4;
    localparam logic [31:0] TRIG_ADDR = BASE_ADDR;
    localparam logic [31:0] JOB_ADDR  = BASE_ADDR + JOB_OFFS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACQ,
        S_ACQ_RSP,
        S_BACKOFF,
        S_WR,
        S_WR_RSP,
        S_TRIG,
        S_TRIG_RSP,
        S_WAIT_EVT
    } state_t;

    state_t state, state_next;

    logic                 armed;
    logic                 req;
    logic [31:0]          add;
    logic                 wen;
    logic [31:0]          wdata;
    logic [ID_WIDTH-1:0]  id;
    logic [ID_WIDTH-1:0]  rsp_id;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     bo_cnt;
    logic [7:0]           job_id;
    logic                 done;
    logic                 err;
    logic [31:0]          job_words [N_REGS];

    logic                 accept;
    logic                 issue;
    logic                 granted;
    logic                 rsp;
    logic [31:0]          issue_add;
    logic                 issue_wen;
    logic [31:0]          issue_data;

    // Only the free/busy flag and the context ID of ACQUIRE are meaningful.
    logic unused_rdata;
    assign unused_rdata = ^periph_r_data_i[30:8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request states are entered with req low; the first cycle there loads
    // the request registers, so each transaction spans issue/req/rsp cycles.
    // The accept itself loads the first ACQUIRE request directly.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        granted    = 1'b0;
        rsp        = 1'b0;
        issue_add  = ACQ_ADDR;
        issue_wen  = 1'b1;
        issue_data = '0;
        case (state)
            S_IDLE: begin
                if (desc_valid_i && armed) begin
                    accept     = 1'b1;
                    state_next = S_ACQ;
                end
            end
            S_ACQ: begin
                if (!req) begin
                    issue = 1'b1;
                end else if (periph_gnt_i) begin
                    granted    = 1'b1;
                    state_next = S_ACQ_RSP;
                end
            end
            S_ACQ_RSP: begin
                if (periph_r_valid_i) begin
                    rsp        = 1'b1;
                    state_next = periph_r_data_i[31] ? S_BACKOFF : S_WR;
                end
            end
            S_BACKOFF: begin
                if (bo_cnt == LAST_CNT) begin
                    state_next = S_ACQ;
                end
            end
            S_WR: begin
                issue_add  = JOB_ADDR + (32'(idx) << 2);
                issue_wen  = 1'b0;
                issue_data = job_words[idx];
                if (!req) begin
                    issue = 1'b1;
                end else if (periph_gnt_i) begin
                    granted    = 1'b1;
                    state_next = S_WR_RSP;
                end
            end
            S_WR_RSP: begin
                if (periph_r_valid_i) begin
                    rsp        = 1'b1;
                    state_next = (idx == LAST_IDX) ? S_TRIG : S_WR;
                end
            end
            S_TRIG: begin
                issue_add = TRIG_ADDR;
                issue_wen = 1'b0;
                if (!req) begin
                    issue = 1'b1;
                end else if (periph_gnt_i) begin
                    granted    = 1'b1;
                    state_next = S_TRIG_RSP;
                end
            end
            S_TRIG_RSP: begin
                if (periph_r_valid_i) begin
                    rsp        = 1'b1;
                    state_next = S_WAIT_EVT;
                end
            end
            S_WAIT_EVT: begin
                if (evt_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed  <= 1'b0;
            req    <= 1'b0;
            add    <= '0;
            wen    <= 1'b1;
            wdata  <= '0;
            id     <= '0;
            rsp_id <= '0;
            idx    <= '0;
            bo_cnt <= '0;
            job_id <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= (state == S_WAIT_EVT) && evt_i;

            if (accept || issue) begin
                req   <= 1'b1;
                add   <= issue_add;
                wen   <= issue_wen;
                wdata <= issue_data;
            end else if (granted) begin
                req    <= 1'b0;
                rsp_id <= id;
                id     <= id + 1'b1;
            end

            if (accept) begin
                err <= 1'b0;
            end else if (rsp && (periph_r_id_i != rsp_id)) begin
                err <= 1'b1;
            end

            if ((state == S_ACQ_RSP) && rsp) begin
                if (periph_r_data_i[31]) begin
                    bo_cnt <= '0;
                end else begin
                    job_id <= periph_r_data_i[7:0];
                    idx    <= '0;
                end
            end

            if (state == S_BACKOFF) begin
                bo_cnt <= bo_cnt + 1'b1;
            end

            if ((state == S_WR_RSP) && rsp && (idx != LAST_IDX)) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Descriptor buffer carries no reset: it is only read after an accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                job_words[i] <= desc_data_i[32*i +: 32];
            end
        end
    end

    assign desc_ready_o  = (state == S_IDLE) && armed;
    assign busy_o        = (state != S_IDLE);
    assign periph_req_o  = req;
    assign periph_add_o  = add;
    assign periph_wen_o  = wen;
    assign periph_be_o   = 4'hF;
    assign periph_data_o = wdata;
    assign periph_id_o   = id;
    assign job_id_o      = job_id;
    assign done_o        = done;
    assign err_o         = err;

endmodule

// File: tb/tb_neureka_job_dispatcher.sv
// tb_neureka_job_dispatcher
//   Directed bench for neureka_job_dispatcher: a responding control-port
//   slave logs every granted request, and the main sequence checks the
//   logged traffic, latencies and status outputs against hand-derived values.
module tb_neureka_job_dispatcher;

    localparam int unsigned N_REGS   = 24;
    localparam int unsigned BACKOFF  = 16;
    localparam int          TRIG_LAT = 3 * (N_REGS + 1) + 1;
    localparam logic [31:0] STALL_ADDR   = 32'h2C;
    localparam logic [31:0] CORRUPT_ADDR = 32'h3C;
    localparam int          LOG_MAX  = 512;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 desc_valid_i = 1'b0;
    logic                 desc_ready_o;
    logic [32*N_REGS-1:0] desc_data_i = '0;
    logic                 periph_req_o;
    logic                 periph_gnt_i = 1'b0;
    logic [31:0]          periph_add_o;
    logic                 periph_wen_o;
    logic [3:0]           periph_be_o;
    logic [31:0]          periph_data_o;
    logic [7:0]           periph_id_o;
    logic                 periph_r_valid_i = 1'b0;
    logic [31:0]          periph_r_data_i = '0;
    logic [7:0]           periph_r_id_i = '0;
    logic                 evt_i = 1'b0;
    logic                 busy_o;
    logic [7:0]           job_id_o;
    logic                 done_o;
    logic                 err_o;

    always #5 clk = ~clk;

    neureka_job_dispatcher #(
        .N_REGS    (N_REGS),
        .ID_WIDTH  (8),
        .BASE_ADDR (32'h0000_0000),
        .JOB_OFFS  (32'h20),
        .BACKOFF   (BACKOFF)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .desc_valid_i     (desc_valid_i),
        .desc_ready_o     (desc_ready_o),
        .desc_data_i      (desc_data_i),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (periph_gnt_i),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_valid_i (periph_r_valid_i),
        .periph_r_data_i  (periph_r_data_i),
        .periph_r_id_i    (periph_r_id_i),
        .evt_i            (evt_i),
        .busy_o           (busy_o),
        .job_id_o         (job_id_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int job_start = 0;

    always @(posedge clk) cyc++;

    // Slave model state
    logic [31:0] acq_q[$];
    logic [31:0] log_add  [LOG_MAX];
    logic [31:0] log_data [LOG_MAX];
    logic        log_wen  [LOG_MAX];
    logic [7:0]  log_id   [LOG_MAX];
    logic [7:0]  log_exp_id [LOG_MAX];
    int          log_cyc  [LOG_MAX];
    int          log_n = 0;
    int          trig_cnt = 0;
    int          done_cnt = 0;
    int          total_grants = 0;
    bit          rsp_pending = 1'b0;
    logic [7:0]  pend_id = '0;
    logic [31:0] pend_rdata = '0;
    bit          stall_en = 1'b0;
    bit          corrupt_en = 1'b0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    logic [31:0] snap_add, snap_data;
    logic        snap_wen;
    logic [7:0]  snap_id;

    always @(negedge clk) begin
        periph_r_valid_i = 1'b0;
        periph_r_id_i    = '0;
        periph_r_data_i  = '0;
        periph_gnt_i     = 1'b0;
        if (done_o) done_cnt++;
        if (!stall_en) stall_seen = 0;
        if (!rst_ni) begin
            rsp_pending  = 1'b0;
            total_grants = 0;
        end else begin
            if (rsp_pending) begin
                periph_r_valid_i = 1'b1;
                periph_r_id_i    = pend_id;
                periph_r_data_i  = pend_rdata;
                rsp_pending      = 1'b0;
            end
            if (periph_req_o) begin
                if (stall_en && !periph_wen_o && periph_add_o == STALL_ADDR && stall_seen < 5) begin
                    if (stall_seen == 0) begin
                        snap_add = periph_add_o; snap_data = periph_data_o;
                        snap_wen = periph_wen_o; snap_id = periph_id_o;
                    end else if (periph_add_o != snap_add || periph_data_o != snap_data ||
                                 periph_wen_o != snap_wen || periph_id_o != snap_id) begin
                        stall_bad++;
                    end
                    stall_seen++;
                end else begin
                    if (stall_en && stall_seen == 5 && periph_add_o == STALL_ADDR && !periph_wen_o &&
                        (periph_data_o != snap_data || periph_id_o != snap_id))
                        stall_bad++;
                    periph_gnt_i = 1'b1;
                    if (log_n < LOG_MAX) begin
                        log_add[log_n]    = periph_add_o;
                        log_data[log_n]   = periph_data_o;
                        log_wen[log_n]    = periph_wen_o;
                        log_id[log_n]     = periph_id_o;
                        log_exp_id[log_n] = 8'(total_grants);
                        log_cyc[log_n]    = cyc;
                    end
                    log_n++;
                    total_grants++;
                    if (!periph_wen_o && periph_add_o == 32'h0) trig_cnt++;
                    pend_id = periph_id_o;
                    if (corrupt_en && !periph_wen_o && periph_add_o == CORRUPT_ADDR)
                        pend_id = pend_id ^ 8'h01;
                    pend_rdata = '0;
                    if (periph_wen_o && acq_q.size() > 0) pend_rdata = acq_q.pop_front();
                    rsp_pending = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(periph_req_o),  32'h0);
        check({tag, "_add"},   periph_add_o,       32'h0);
        check({tag, "_wen"},   32'(periph_wen_o),  32'h1);
        check({tag, "_data"},  periph_data_o,      32'h0);
        check({tag, "_id"},    32'(periph_id_o),   32'h0);
        check({tag, "_be"},    32'(periph_be_o),   32'hF);
        check({tag, "_ready"}, 32'(desc_ready_o),  32'h0);
        check({tag, "_busy"},  32'(busy_o),        32'h0);
        check({tag, "_jobid"}, 32'(job_id_o),      32'h0);
        check({tag, "_done"},  32'(done_o),        32'h0);
        check({tag, "_err"},   32'(err_o),         32'h0);
    endtask

    task automatic send_desc(input logic [31:0] base);
        int k = 0;
        for (int i = 0; i < N_REGS; i++) desc_data_i[i*32 +: 32] = base + 32'(i);
        while (!desc_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("desc_ready_wait", 32'(k < 100), 32'h1);
        job_start    = log_n;
        acc_cyc      = cyc;
        desc_valid_i = 1'b1;
        @(negedge clk);
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int target);
        int k = 0;
        while (log_n < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_log_wait"}, 32'(k < 2000), 32'h1);
    endtask

    task automatic finish_job(input string tag);
        int t0 = trig_cnt;
        int k = 0;
        while (trig_cnt == t0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_trig_wait"}, 32'(k < 2000), 32'h1);
        repeat (3) @(negedge clk);
        check({tag, "_busy_wait"}, 32'(busy_o), 32'h1);
        check({tag, "_done_pre"},  32'(done_o), 32'h0);
        evt_i = 1'b1;
        @(negedge clk);
        evt_i = 1'b0;
        check({tag, "_done"},      32'(done_o), 32'h1);
        check({tag, "_busy_end"},  32'(busy_o), 32'h0);
        check({tag, "_ready_end"}, 32'(desc_ready_o), 32'h1);
        @(negedge clk);
        check({tag, "_done_off"},  32'(done_o), 32'h0);
    endtask

    task automatic verify_job(input string tag, input int n_reads, input logic [31:0] base);
        int e;
        int id_bad = 0;
        check({tag, "_ntx"}, 32'(log_n - job_start), 32'(n_reads + N_REGS + 1));
        for (int k = 0; k < n_reads; k++) begin
            e = job_start + k;
            check($sformatf("%s_radd%0d", tag, k), log_add[e], 32'h4);
            check($sformatf("%s_rwen%0d", tag, k), 32'(log_wen[e]), 32'h1);
        end
        for (int i = 0; i < N_REGS; i++) begin
            e = job_start + n_reads + i;
            check($sformatf("%s_wadd%0d", tag, i), log_add[e], 32'h20 + 32'(4 * i));
            check($sformatf("%s_wdat%0d", tag, i), log_data[e], base + 32'(i));
            check($sformatf("%s_wwen%0d", tag, i), 32'(log_wen[e]), 32'h0);
        end
        e = job_start + n_reads + N_REGS;
        check({tag, "_tadd"}, log_add[e], 32'h0);
        check({tag, "_tdat"}, log_data[e], 32'h0);
        check({tag, "_twen"}, 32'(log_wen[e]), 32'h0);
        for (int k = job_start; k <= e; k++) if (log_id[k] !== log_exp_id[k]) id_bad++;
        check({tag, "_id_seq"}, 32'(id_bad), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_rst", 32'(desc_ready_o), 32'h1);

        // Free context on first ACQUIRE
        acq_q.push_back(32'h0000_0002);
        send_desc(32'h100);
        finish_job("free");
        verify_job("free", 1, 32'h100);
        check("free_jobid", 32'(job_id_o), 32'h2);
        check("free_err", 32'(err_o), 32'h0);
        check("free_acq_lat", 32'(log_cyc[job_start] - acc_cyc), 32'h1);
        check("free_trig_lat", 32'(log_cyc[job_start + 1 + N_REGS] - acc_cyc), 32'(TRIG_LAT));

        // Two failed ACQUIREs, then success
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'h0000_0001);
        send_desc(32'h2000);
        finish_job("bo");
        verify_job("bo", 3, 32'h2000);
        s = job_start;
        check("bo_gap1", 32'((log_cyc[s + 1] - log_cyc[s]) >= int'(BACKOFF + 1)), 32'h1);
        check("bo_gap2", 32'((log_cyc[s + 2] - log_cyc[s + 1]) >= int'(BACKOFF + 1)), 32'h1);
        check("bo_jobid", 32'(job_id_o), 32'h1);

        // Grant held low for 5 cycles on write 3
        stall_en = 1'b1;
        acq_q.push_back(32'h0000_0005);
        send_desc(32'hA000_0000);
        finish_job("stall");
        verify_job("stall", 1, 32'hA000_0000);
        check("stall_cycles", 32'(stall_seen), 32'h5);
        check("stall_stable", 32'(stall_bad), 32'h0);
        check("stall_jobid", 32'(job_id_o), 32'h5);
        stall_en = 1'b0;

        // Response ID corrupted on write 7
        corrupt_en = 1'b1;
        acq_q.push_back(32'h0000_0007);
        send_desc(32'h5500);
        wait_log("idm", job_start + 5);
        check("idm_err_before", 32'(err_o), 32'h0);
        finish_job("idm");
        check("idm_err_after_done", 32'(err_o), 32'h1);
        verify_job("idm", 1, 32'h5500);
        corrupt_en = 1'b0;

        // Event pulsed during the register writes is ignored
        acq_q.push_back(32'h0000_0004);
        send_desc(32'h7700);
        check("early_err_cleared", 32'(err_o), 32'h0);
        wait_log("early", job_start + 6);
        s = done_cnt;
        evt_i = 1'b1;
        @(negedge clk);
        evt_i = 1'b0;
        repeat (2) @(negedge clk);
        check("early_busy", 32'(busy_o), 32'h1);
        finish_job("early");
        check("early_done_count", 32'(done_cnt - s), 32'h1);
        verify_job("early", 1, 32'h7700);
        check("early_jobid", 32'(job_id_o), 32'h4);

        // Reset while waiting for a write response
        acq_q.push_back(32'h0000_0009);
        send_desc(32'hC000);
        begin
            int k = 0;
            while (log_n < job_start + 4 && k < 2000) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("mid_log_wait", 32'(k < 2000), 32'h1);
        end
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_ready_after", 32'(desc_ready_o), 32'h1);
        check("mid_busy_after", 32'(busy_o), 32'h0);
        acq_q.push_back(32'h0000_0003);
        send_desc(32'hE000);
        finish_job("post");
        verify_job("post", 1, 32'hE000);
        check("post_first_id", 32'(log_id[job_start]), 32'h0);
        check("post_jobid", 32'(job_id_o), 32'h3);
        check("post_err", 32'(err_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
